trap_ctrl: RTL and testbench

//  Trap/return sequencer in front of the machine-mode CSR file.
//  - Arbitrates synchronous exceptions, MRET and pending interrupts.
//  - Stalls and flushes the pipeline, then drains outstanding LSU traffic.
//  - Issues single-cycle CSR update strobes (trap entry / MRET).
//  - Redirects fetch to the handler or to the return address.

---
 rtl/trap_pkg.sv | 33 +++
 rtl/trap_ctrl_irq_prio.sv | 35 +++
 rtl/trap_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap/return sequencer.
// Cause codes follow the machine-mode mcause encoding.
package trap_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      COMMIT   = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      K_EXC  = 2'd0,
      K_IRQ  = 2'd1,
      K_MRET = 2'd2
   } kind_t;

   localparam logic [3:0] EXC_ILLEGAL    = 4'd2;
   localparam logic [3:0] EXC_BREAKPOINT = 4'd3;
   localparam logic [3:0] EXC_ECALL      = 4'd11;

   localparam logic [3:0] IRQ_MSI = 4'd3;
   localparam logic [3:0] IRQ_MTI = 4'd7;
   localparam logic [3:0] IRQ_MEI = 4'd11;

   // Bit positions inside the {meip,mtip,msip} / {meie,mtie,msie} vectors
   localparam int IRQ_BIT_MSI = 0;
   localparam int IRQ_BIT_MTI = 1;
   localparam int IRQ_BIT_MEI = 2;

   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// Pending-interrupt qualifier and fixed-priority encoder.
// Priority order is external > software > timer.
module irq_prio
   import trap_pkg::*;
(
   input  logic [2:0] mip_bits,
   input  logic [2:0] mie_bits,
   input  logic       mstatus_mie,
   output logic       take,
   output logic [3:0] code
);

   logic [2:0] pend;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_pend
         assign pend[gi] = mip_bits[gi] & mie_bits[gi] & mstatus_mie;
      end
   endgenerate

   assign take = |pend;

   always_comb begin
      code = 4'd0;
      if (pend[IRQ_BIT_MEI]) begin
         code = IRQ_MEI;
      end else if (pend[IRQ_BIT_MSI]) begin
         code = IRQ_MSI;
      end else if (pend[IRQ_BIT_MTI]) begin
         code = IRQ_MTI;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: arbitrates exceptions, MRET and interrupts, drains the LSU,
// strobes the CSR update and redirects fetch to the handler or return address.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DRAIN_MAX = 15
)
(
   input  logic            clk_in,
   input  logic            rst_n,
   input  logic            exc_req,
   input  logic [3:0]      exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            mret_req,
   input  logic [2:0]      mip_bits,
   input  logic [2:0]      mie_bits,
   input  logic            mstatus_mie,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   input  logic [XLEN-1:0] next_pc,
   input  logic            lsu_busy,
   output logic            ack,
   output logic            stall,
   output logic            flush,
   output logic            trap_we,
   output logic            mret_we,
   output logic [XLEN-1:0] trap_cause,
   output logic [XLEN-1:0] trap_epc,
   output logic [XLEN-1:0] trap_tval,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            drain_err
);

   localparam int CW = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX + 1);
   // Last DRAIN cycle index: DRAIN lasts at most DRAIN_MAX cycles
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX - 1);

   state_t          state_reg, state_next;
   kind_t           kind_reg, kind_next;
   logic [XLEN-1:0] cause_reg, cause_next;
   logic [XLEN-1:0] epc_reg, epc_next;
   logic [XLEN-1:0] tval_reg, tval_next;
   logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;
   logic [CW-1:0]   drain_cnt_reg, drain_cnt_next;
   logic            flush_reg, flush_next;
   logic            guard_reg, guard_next;

   logic            ack_c;
   logic            drain_err_c;
   logic            accept;

   logic            irq_take;
   logic [3:0]      irq_code;

   logic [XLEN-1:0] mtvec_base;
   logic [XLEN-1:0] vec_offset;

   irq_prio u_irq_prio (
      .mip_bits    (mip_bits),
      .mie_bits    (mie_bits),
      .mstatus_mie (mstatus_mie),
      .take        (irq_take),
      .code        (irq_code)
   );

   assign mtvec_base = {mtvec[XLEN-1:2], 2'b00};
   assign vec_offset = {{(XLEN-6){1'b0}}, cause_reg[3:0], 2'b00};

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         kind_reg        <= K_EXC;
         cause_reg       <= '0;
         epc_reg         <= '0;
         tval_reg        <= '0;
         redirect_pc_reg <= '0;
         drain_cnt_reg   <= '0;
         flush_reg       <= 1'b0;
         guard_reg       <= 1'b0;
      end else begin
         state_reg       <= state_next;
         kind_reg        <= kind_next;
         cause_reg       <= cause_next;
         epc_reg         <= epc_next;
         tval_reg        <= tval_next;
         redirect_pc_reg <= redirect_pc_next;
         drain_cnt_reg   <= drain_cnt_next;
         flush_reg       <= flush_next;
         guard_reg       <= guard_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      kind_next        = kind_reg;
      cause_next       = cause_reg;
      epc_next         = epc_reg;
      tval_next        = tval_reg;
      redirect_pc_next = redirect_pc_reg;
      drain_cnt_next   = drain_cnt_reg;
      flush_next       = 1'b0;
      guard_next       = 1'b0;
      ack_c            = 1'b0;
      drain_err_c      = 1'b0;
      accept           = 1'b0;

      case (state_reg)
         IDLE: begin
            if (exc_req) begin
               accept     = 1'b1;
               kind_next  = K_EXC;
               cause_next = {{(XLEN-4){1'b0}}, exc_cause};
               epc_next   = exc_pc;
               tval_next  = exc_tval;
               flush_next = 1'b1;
            end else if (mret_req) begin
               accept     = 1'b1;
               kind_next  = K_MRET;
            end else if (irq_take && !guard_reg) begin
               // guard_reg masks the cycle right after REDIRECT while MIE settles
               accept     = 1'b1;
               kind_next  = K_IRQ;
               cause_next = {1'b1, {(XLEN-5){1'b0}}, irq_code};
               epc_next   = next_pc;
               tval_next  = '0;
               flush_next = 1'b1;
            end
            if (accept) begin
               ack_c      = 1'b1;
               state_next = lsu_busy ? DRAIN : COMMIT;
            end
         end

         DRAIN: begin
            if (!lsu_busy) begin
               state_next     = COMMIT;
               drain_cnt_next = '0;
            end else if (drain_cnt_reg == DRAIN_LAST) begin
               state_next     = COMMIT;
               drain_cnt_next = '0;
               drain_err_c    = 1'b1;
            end else begin
               drain_cnt_next = drain_cnt_reg + CW'(1);
            end
         end

         COMMIT: begin
            state_next = REDIRECT;
            case (kind_reg)
               K_IRQ: begin
                  if (mtvec[1:0] == MTVEC_VECTORED) begin
                     redirect_pc_next = mtvec_base + vec_offset;
                  end else begin
                     redirect_pc_next = mtvec_base;
                  end
               end
               K_MRET:  redirect_pc_next = mepc;
               default: redirect_pc_next = mtvec_base;
            endcase
         end

         REDIRECT: begin
            state_next = IDLE;
            guard_next = 1'b1;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Strobes are masked by rst_n so a reset landing mid-sequence emits nothing
   assign ack            = ack_c & rst_n;
   assign stall          = (state_reg != IDLE);
   assign flush          = flush_reg;
   assign trap_we        = rst_n & (state_reg == COMMIT) & (kind_reg != K_MRET);
   assign mret_we        = rst_n & (state_reg == COMMIT) & (kind_reg == K_MRET);
   assign trap_cause     = cause_reg;
   assign trap_epc       = epc_reg;
   assign trap_tval      = tval_reg;
   assign redirect_valid = rst_n & (state_reg == REDIRECT);
   assign redirect_pc    = redirect_pc_reg;
   assign drain_err      = drain_err_c & rst_n;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: each transaction is stepped cycle by cycle
// against hand-computed expected strobes, causes and redirect targets.
module tb_trap_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_n;
   logic        exc_req;
   logic [3:0]  exc_cause;
   logic [31:0] exc_pc;
   logic [31:0] exc_tval;
   logic        mret_req;
   logic [2:0]  mip_bits;
   logic [2:0]  mie_bits;
   logic        mstatus_mie;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic [31:0] next_pc;
   logic        lsu_busy;
   logic        ack;
   logic        stall;
   logic        flush;
   logic        trap_we;
   logic        mret_we;
   logic [31:0] trap_cause;
   logic [31:0] trap_epc;
   logic [31:0] trap_tval;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        drain_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   trap_ctrl #(.XLEN(32), .DRAIN_MAX(15)) dut (
      .clk_in         (clk_in),
      .rst_n          (rst_n),
      .exc_req        (exc_req),
      .exc_cause      (exc_cause),
      .exc_pc         (exc_pc),
      .exc_tval       (exc_tval),
      .mret_req       (mret_req),
      .mip_bits       (mip_bits),
      .mie_bits       (mie_bits),
      .mstatus_mie    (mstatus_mie),
      .mtvec          (mtvec),
      .mepc           (mepc),
      .next_pc        (next_pc),
      .lsu_busy       (lsu_busy),
      .ack            (ack),
      .stall          (stall),
      .flush          (flush),
      .trap_we        (trap_we),
      .mret_we        (mret_we),
      .trap_cause     (trap_cause),
      .trap_epc       (trap_epc),
      .trap_tval      (trap_tval),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .drain_err      (drain_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here,
   // outputs are sampled one time unit later.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; exc_req = 1'b0; exc_cause = 4'd0; exc_pc = '0; exc_tval = '0;
      mret_req = 1'b0; mip_bits = 3'b000; mie_bits = 3'b000; mstatus_mie = 1'b0;
      mtvec = '0; mepc = '0; next_pc = '0; lsu_busy = 1'b0;

      // ---- reset state
      tick(); tick();
      #1;
      check_eq("rst_stall", stall, 1'b0);
      check_eq("rst_ack", ack, 1'b0);
      check_eq("rst_flush", flush, 1'b0);
      check_eq("rst_trap_we", trap_we, 1'b0);
      check_eq("rst_redirect", redirect_valid, 1'b0);
      check_eq("rst_redirect_pc", redirect_pc, 32'h0);
      check_eq("rst_cause", trap_cause, 32'h0);
      $display("txn reset done");

      // ---- 1: ecall, no drain
      tick();
      rst_n = 1'b1; mtvec = 32'h800;
      exc_req = 1'b1; exc_cause = 4'd11; exc_pc = 32'h100; exc_tval = 32'h0;
      #1;
      check_eq("ecall_ack", ack, 1'b1);
      check_eq("ecall_stall_T", stall, 1'b0);
      tick(); exc_req = 1'b0; #1;
      check_eq("ecall_flush", flush, 1'b1);
      check_eq("ecall_trap_we", trap_we, 1'b1);
      check_eq("ecall_cause", trap_cause, 32'd11);
      check_eq("ecall_epc", trap_epc, 32'h100);
      check_eq("ecall_stall", stall, 1'b1);
      tick(); #1;
      check_eq("ecall_redir_v", redirect_valid, 1'b1);
      check_eq("ecall_redir_pc", redirect_pc, 32'h800);
      check_eq("ecall_flush_off", flush, 1'b0);
      check_eq("ecall_we_off", trap_we, 1'b0);
      $display("txn ecall done");

      // ---- 2: vectored timer irq; first IDLE cycle is the re-entry guard
      tick();
      mtvec = 32'h801; mstatus_mie = 1'b1; mie_bits = 3'b010; mip_bits = 3'b010; next_pc = 32'h204;
      #1;
      check_eq("guard_idle", stall, 1'b0);
      check_eq("guard_no_ack", ack, 1'b0);
      tick(); #1;
      check_eq("tmr_ack", ack, 1'b1);
      tick(); mstatus_mie = 1'b0; #1;
      check_eq("tmr_flush", flush, 1'b1);
      check_eq("tmr_trap_we", trap_we, 1'b1);
      check_eq("tmr_cause", trap_cause, 32'h8000_0007);
      check_eq("tmr_epc", trap_epc, 32'h204);
      check_eq("tmr_tval", trap_tval, 32'h0);
      tick(); #1;
      check_eq("tmr_redir_v", redirect_valid, 1'b1);
      check_eq("tmr_redir_pc", redirect_pc, 32'h81C);
      $display("txn timer irq done");

      // ---- 3: exception beats all irqs, then mret, then irq after MIE restored
      tick();
      mstatus_mie = 1'b1; mip_bits = 3'b111; mie_bits = 3'b111;
      exc_req = 1'b1; exc_cause = 4'd2; exc_pc = 32'h400; exc_tval = 32'hDEAD_BEEF;
      #1;
      check_eq("prio_ack", ack, 1'b1);
      tick(); exc_req = 1'b0; mstatus_mie = 1'b0; #1;
      check_eq("prio_trap_we", trap_we, 1'b1);
      check_eq("prio_cause", trap_cause, 32'd2);
      check_eq("prio_tval", trap_tval, 32'hDEAD_BEEF);
      tick(); #1;
      check_eq("prio_redir_pc", redirect_pc, 32'h800);
      $display("txn illegal over irqs done");

      tick();
      mret_req = 1'b1; mepc = 32'h300;
      #1;
      check_eq("mret_ack", ack, 1'b1);
      tick(); mret_req = 1'b0; #1;
      check_eq("mret_we", mret_we, 1'b1);
      check_eq("mret_no_trap_we", trap_we, 1'b0);
      check_eq("mret_no_flush", flush, 1'b0);
      check_eq("mret_cause_kept", trap_cause, 32'd2);
      tick(); mstatus_mie = 1'b1; #1;
      check_eq("mret_redir_v", redirect_valid, 1'b1);
      check_eq("mret_redir_pc", redirect_pc, 32'h300);
      tick(); #1;
      check_eq("mret_guard_no_ack", ack, 1'b0);
      tick(); #1;
      check_eq("mei_ack", ack, 1'b1);
      tick(); mstatus_mie = 1'b0; #1;
      check_eq("mei_cause", trap_cause, 32'h8000_000B);
      tick(); #1;
      check_eq("mei_redir_pc", redirect_pc, 32'h82C);
      $display("txn mret + external irq done");

      // ---- 6b: irqs pending but globally or locally masked
      tick(); tick(); #1;
      check_eq("mie0_no_ack", ack, 1'b0);
      mstatus_mie = 1'b1; mie_bits = 3'b000; #1;
      check_eq("mask0_no_ack", ack, 1'b0);
      tick(); #1;
      check_eq("mask0_idle", stall, 1'b0);
      mip_bits = 3'b000; mstatus_mie = 1'b0;
      $display("txn masked irq done");

      // ---- 4a: lsu_busy high 3 cycles from ack
      tick();
      lsu_busy = 1'b1; exc_req = 1'b1; exc_cause = 4'd3; exc_pc = 32'h500; exc_tval = 32'h0;
      #1;
      check_eq("drn_ack", ack, 1'b1);
      tick(); exc_req = 1'b0; #1;
      check_eq("drn_flush", flush, 1'b1);
      check_eq("drn_no_we1", trap_we, 1'b0);
      check_eq("drn_stall", stall, 1'b1);
      tick(); #1;
      check_eq("drn_no_we2", trap_we, 1'b0);
      tick(); lsu_busy = 1'b0; #1;
      check_eq("drn_no_we3", trap_we, 1'b0);
      check_eq("drn_no_err", drain_err, 1'b0);
      tick(); #1;
      check_eq("drn_trap_we", trap_we, 1'b1);
      check_eq("drn_cause", trap_cause, 32'd3);
      check_eq("drn_no_err2", drain_err, 1'b0);
      tick(); #1;
      check_eq("drn_redir_pc", redirect_pc, 32'h800);
      $display("txn drain release done");

      // ---- 4b: lsu_busy stuck -> timeout on the 15th DRAIN cycle
      tick();
      lsu_busy = 1'b1; exc_req = 1'b1; exc_cause = 4'd11; exc_pc = 32'h600;
      #1;
      check_eq("to_ack", ack, 1'b1);
      for (int i = 1; i <= 14; i++) begin
         tick(); exc_req = 1'b0; #1;
         check_eq($sformatf("to_wait%0d_err", i), drain_err, 1'b0);
         check_eq($sformatf("to_wait%0d_we", i), trap_we, 1'b0);
      end
      tick(); #1;
      check_eq("to_drain_err", drain_err, 1'b1);
      check_eq("to_stall", stall, 1'b1);
      tick(); lsu_busy = 1'b0; #1;
      check_eq("to_trap_we", trap_we, 1'b1);
      check_eq("to_err_off", drain_err, 1'b0);
      check_eq("to_epc", trap_epc, 32'h600);
      tick(); #1;
      check_eq("to_redir_v", redirect_valid, 1'b1);
      $display("txn drain timeout done");

      // ---- 5: reset during DRAIN
      tick(); tick();
      lsu_busy = 1'b1; exc_req = 1'b1; exc_cause = 4'd2; exc_pc = 32'h700;
      #1;
      check_eq("rd_ack", ack, 1'b1);
      tick(); exc_req = 1'b0; #1;
      tick(); rst_n = 1'b0; #1;
      check_eq("rd_no_we_in_rst", trap_we, 1'b0);
      tick(); #1;
      check_eq("rd_stall", stall, 1'b0);
      check_eq("rd_flush", flush, 1'b0);
      check_eq("rd_trap_we", trap_we, 1'b0);
      check_eq("rd_redir_v", redirect_valid, 1'b0);
      check_eq("rd_redir_pc", redirect_pc, 32'h0);
      check_eq("rd_cause", trap_cause, 32'h0);
      check_eq("rd_epc", trap_epc, 32'h0);
      check_eq("rd_drain_err", drain_err, 1'b0);
      rst_n = 1'b1; lsu_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         check_eq($sformatf("rd_quiet%0d_we", i), trap_we, 1'b0);
         check_eq($sformatf("rd_quiet%0d_rv", i), redirect_valid, 1'b0);
      end
      exc_req = 1'b1; exc_cause = 4'd11; exc_pc = 32'h900;
      #1;
      check_eq("rd_new_ack", ack, 1'b1);
      tick(); exc_req = 1'b0; #1;
      check_eq("rd_new_we", trap_we, 1'b1);
      check_eq("rd_new_epc", trap_epc, 32'h900);
      tick(); #1;
      check_eq("rd_new_redir_pc", redirect_pc, 32'h800);
      $display("txn reset mid-drain done");

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
